fb_line_writer: RTL

Bresenham line rasteriser that writes one colour index per pixel into the 160×120 4-bit framebuffer through the BRAM write port, in the system clock domain. It sits directly upstream of the framebuffer → linebuffer → CLUT display path. It accepts one line command at a time over a start/busy/done handshake, can be paced by a draw-enable input, and clips pixels that fall outside the framebuffer.

---
 rtl/fb_line_writer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fb_line_writer.sv
// fb_line_writer
// Bresenham line rasteriser feeding the 160x120, 4-bit framebuffer write port.
// One line command is accepted at a time. Drawing always runs top-to-bottom,
// because the endpoints are swapped when y0 > y1. Pixels outside the
// framebuffer still take their step, but they are not written.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   start             command strobe, sampled only while idle
//   oe                draw enable; the DRAW state advances only while oe=1
//   x0,y0,x1,y1       signed line endpoints, sampled with start
//   colr              colour index, sampled with start
//   busy              a command is in progress (through the done cycle)
//   done              one-cycle pulse in the final pixel's write slot
//   fb_we             framebuffer write enable (registered)
//   fb_addr           write address y*FB_WIDTH + x (registered)
//   fb_colr           write data (registered)
module fb_line_writer #(
  parameter int CORDW     = 9,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int CIDXW     = 4,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic [CIDXW-1:0]        colr,
  output logic                    busy,
  output logic                    done,
  output logic                    fb_we,
  output logic [FB_ADDRW-1:0]     fb_addr,
  output logic [CIDXW-1:0]        fb_colr
);

  typedef enum logic [2:0] {IDLE, INIT_0, INIT_1, DRAW, DONE} state_t;

  state_t state_r, state_next_s;

  logic signed [CORDW-1:0] x0_r, y0_r, x1_r, y1_r, x_r, y_r;
  logic [CIDXW-1:0]        colr_r;
  logic signed [CORDW:0]   dx_r, dy_r, err_r;
  logic                    right_r;

  logic                    swap_s;
  logic signed [CORDW-1:0] sx0_s, sy0_s, sx1_s, sy1_s;
  logic signed [CORDW:0]   dx_diff_s, dx_abs_s, dy_s, err_next_s;
  logic signed [CORDW+1:0] e2_s;
  logic                    step_x_s, step_y_s, last_s, in_range_s, pix_we_s;
  logic [FB_ADDRW-1:0]     addr_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = INIT_0;
        else       state_next_s = IDLE;
      end
      INIT_0: state_next_s = INIT_1;
      INIT_1: state_next_s = DRAW;
      DRAW: begin
        if (oe && last_s) state_next_s = DONE;
        else              state_next_s = DRAW;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Endpoint ordering, Bresenham step decisions, clipping and address
  always_comb begin
    swap_s    = (y0_r > y1_r);
    sx0_s     = swap_s ? x1_r : x0_r;
    sy0_s     = swap_s ? y1_r : y0_r;
    sx1_s     = swap_s ? x0_r : x1_r;
    sy1_s     = swap_s ? y0_r : y1_r;
    dx_diff_s = (CORDW+1)'(sx1_s) - (CORDW+1)'(sx0_s);
    if (dx_diff_s[CORDW]) dx_abs_s = -dx_diff_s;
    else                  dx_abs_s = dx_diff_s;
    dy_s      = (CORDW+1)'(sy0_s) - (CORDW+1)'(sy1_s);
    e2_s      = {err_r, 1'b0};
    // Signed size casts sign-extend dx/dy to the width of e2.
    step_x_s  = (e2_s >= (CORDW+2)'(dy_r));
    step_y_s  = (e2_s <= (CORDW+2)'(dx_r));
    // Both adjustments fold into one update when both steps are taken.
    err_next_s = err_r + (step_x_s ? dy_r : {(CORDW+1){1'b0}})
                       + (step_y_s ? dx_r : {(CORDW+1){1'b0}});
    last_s     = (x_r == x1_r) && (y_r == y1_r);
    // The sign bit rules out negative coordinates. After that, unsigned
    // upper-bound compares are safe.
    in_range_s = !x_r[CORDW-1] && !y_r[CORDW-1] &&
                 ($unsigned(x_r) < CORDW'(FB_WIDTH)) &&
                 ($unsigned(y_r) < CORDW'(FB_HEIGHT));
    // Widen to the full address width before multiplying, so the product
    // is not truncated.
    addr_s     = FB_ADDRW'($unsigned(y_r)) * FB_ADDRW'(FB_WIDTH) +
                 FB_ADDRW'($unsigned(x_r));
    pix_we_s   = (state_r == DRAW) && oe && in_range_s;
  end

  // Command capture, line setup and per-pixel stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r    <= '0;
      y0_r    <= '0;
      x1_r    <= '0;
      y1_r    <= '0;
      x_r     <= '0;
      y_r     <= '0;
      colr_r  <= '0;
      dx_r    <= '0;
      dy_r    <= '0;
      err_r   <= '0;
      right_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x0_r   <= x0;
            y0_r   <= y0;
            x1_r   <= x1;
            y1_r   <= y1;
            colr_r <= colr;
          end
        end
        INIT_0: begin
          x0_r    <= sx0_s;
          y0_r    <= sy0_s;
          x1_r    <= sx1_s;
          y1_r    <= sy1_s;
          dx_r    <= dx_abs_s;
          dy_r    <= dy_s;
          right_r <= (sx0_s < sx1_s);
        end
        INIT_1: begin
          x_r   <= x0_r;
          y_r   <= y0_r;
          err_r <= dx_r + dy_r;
        end
        DRAW: begin
          if (oe && !last_s) begin
            if (step_x_s) x_r <= right_r ? x_r + CORDW'(1) : x_r - CORDW'(1);
            if (step_y_s) y_r <= y_r + CORDW'(1);
            err_r <= err_next_s;
          end
        end
        default: begin
          x_r <= x_r;
        end
      endcase
    end
  end

  // Registered status and framebuffer write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_colr <= '0;
    end else begin
      busy  <= (state_next_s != IDLE);
      done  <= (state_next_s == DONE);
      fb_we <= pix_we_s;
      if (pix_we_s) begin
        fb_addr <= addr_s;
        fb_colr <= colr_r;
      end
    end
  end

endmodule
